// File: rtl/imem_loader_if.sv
// Load-port bundle between the byte source / control side and the instruction-memory loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              ImemWrite;
  logic [15:0]       ImemData;
  logic [ADDR_W-1:0] addr_to_write;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output start, rx_valid, rx_data,
    input  ImemWrite, ImemData, addr_to_write, load_busy, load_done, load_err
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output ImemWrite, ImemData, addr_to_write, load_busy, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Frames a serial byte stream (count header, 16-bit payload words, XOR checksum) into
// instruction-memory write pulses and reports busy/done/error for the CPU reset hold.
module imem_loader #(
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave io_bus
);

  localparam int unsigned       Depth   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StCntHi, StCntLo, StDatHi, StDatLo, StChk, StDone, StErr
  } state_e;

  state_e            r_state, w_state;
  logic [7:0]        r_cnt_hi, w_cnt_hi;
  logic [7:0]        r_hi, w_hi;
  logic [7:0]        r_csum, w_csum;
  logic [ADDR_W:0]   r_remain, w_remain;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_wr, w_wr;
  logic [15:0]       r_data, w_data;
  logic [ADDR_W-1:0] r_waddr, w_waddr;
  logic [CNT_W-1:0]  r_tmo, w_tmo;

  logic        w_byte;
  logic [15:0] w_count;
  logic        w_busy;

  assign w_byte  = io_bus.rx_valid;
  assign w_count = {r_cnt_hi, io_bus.rx_data};
  assign w_busy  = r_state inside {StCntHi, StCntLo, StDatHi, StDatLo, StChk};

  always_comb begin
    w_state  = r_state;
    w_cnt_hi = r_cnt_hi;
    w_hi     = r_hi;
    w_csum   = r_csum;
    w_remain = r_remain;
    w_addr   = r_addr;
    w_wr     = 1'b0;
    w_data   = r_data;
    w_waddr  = r_waddr;
    w_tmo    = '0;

    unique case (r_state)
      // Bytes arriving alongside a start (or with no start) are dropped here.
      StIdle, StDone, StErr: begin
        if (io_bus.start) begin
          w_state = StCntHi;
          w_csum  = '0;
          w_addr  = '0;
          w_waddr = '0;
        end
      end
      StCntHi: begin
        if (w_byte) begin
          w_cnt_hi = io_bus.rx_data;
          w_state  = StCntLo;
        end
      end
      StCntLo: begin
        if (w_byte) begin
          if (w_count == 16'h0 || {16'h0, w_count} > Depth) begin
            w_state = StErr;
          end else begin
            w_remain = w_count[ADDR_W:0];
            w_state  = StDatHi;
          end
        end
      end
      StDatHi: begin
        if (w_byte) begin
          w_hi    = io_bus.rx_data;
          w_csum  = r_csum ^ io_bus.rx_data;
          w_state = StDatLo;
        end
      end
      StDatLo: begin
        if (w_byte) begin
          w_wr     = 1'b1;
          w_data   = {r_hi, io_bus.rx_data};
          w_waddr  = r_addr;
          w_addr   = r_addr + 1'b1;
          w_csum   = r_csum ^ io_bus.rx_data;
          w_remain = r_remain - 1'b1;
          w_state  = (r_remain == {{ADDR_W{1'b0}}, 1'b1}) ? StChk : StDatHi;
        end
      end
      StChk: begin
        if (w_byte) begin
          w_state = (io_bus.rx_data == r_csum) ? StDone : StErr;
        end
      end
      default: w_state = StIdle;
    endcase

    // Inter-byte watchdog; only runs while a frame is in progress.
    if (w_busy && !w_byte) begin
      if (r_tmo == TmoLast) begin
        w_state = StErr;
      end else begin
        w_tmo = r_tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt_hi <= '0;
      r_hi     <= '0;
      r_csum   <= '0;
      r_remain <= '0;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_data   <= '0;
      r_waddr  <= '0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt_hi <= w_cnt_hi;
      r_hi     <= w_hi;
      r_csum   <= w_csum;
      r_remain <= w_remain;
      r_addr   <= w_addr;
      r_wr     <= w_wr;
      r_data   <= w_data;
      r_waddr  <= w_waddr;
      r_tmo    <= w_tmo;
    end
  end

  assign io_bus.ImemWrite     = r_wr;
  assign io_bus.ImemData      = r_data;
  assign io_bus.addr_to_write = r_waddr;
  assign io_bus.load_busy     = w_busy;
  assign io_bus.load_done     = (r_state == StDone);
  assign io_bus.load_err      = (r_state == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader with a queue-based reference of expected writes.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned TMO    = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    int                cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pw_viol = 0;
  logic prev_wr = 1'b0;
  wr_t  mon_q[$];
  logic [15:0] tx_words[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes, sampled half a cycle after the edge that launches them.
  always @(negedge clk) begin
    if (bus.ImemWrite === 1'b1) begin
      mon_q.push_back('{addr: bus.addr_to_write, data: bus.ImemData, cyc: cyc});
      if (prev_wr) pw_viol <= pw_viol + 1;
    end
    prev_wr <= (bus.ImemWrite === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycle();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic pulse_start(input bit junk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.rx_valid = junk;
    bus.rx_data  = 8'hFF;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int drv_cyc);
    for (int i = 0; i < gap; i++) idle_cycle();
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    drv_cyc      = cyc;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (bus.load_busy === 1'b1 && n < budget) begin
      idle_cycle();
      n++;
    end
    checks++;
    if (bus.load_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait: load_busy got %b required 0 within %0d cycles", name, bus.load_busy,
               budget);
    end
  endtask

  // One framed load: the model decides from the frame contents which writes and which flag result.
  task automatic load_and_check(input string name, input logic [15:0] cnt, input bit force_csum,
                                input logic [7:0] forced, input int max_gap, input bit junk);
    wr_t        exp_q[$];
    logic [7:0] csum;
    logic [7:0] sent;
    bit         cnt_bad;
    bit         exp_done;
    int         dc;
    int         pw0;
    csum    = 8'h00;
    sent    = 8'h00;
    cnt_bad = (cnt == 16'h0) || (int'(cnt) > DEPTH);
    pw0     = pw_viol;
    mon_q.delete();

    pulse_start(junk);
    checks++;
    if ({bus.load_busy, bus.load_done, bus.load_err} !== 3'b100) begin
      errors++;
      $display("FAIL %s_start_flags: busy/done/err got %b%b%b required 100", name, bus.load_busy,
               bus.load_done, bus.load_err);
    end

    send_byte(cnt[15:8], $urandom_range(0, max_gap), dc);
    send_byte(cnt[7:0], $urandom_range(0, max_gap), dc);
    if (!cnt_bad) begin
      for (int i = 0; i < int'(cnt); i++) begin
        logic [15:0] w;
        w = tx_words[i];
        send_byte(w[15:8], $urandom_range(0, max_gap), dc);
        send_byte(w[7:0], $urandom_range(0, max_gap), dc);
        exp_q.push_back('{addr: ADDR_W'(i), data: w, cyc: dc + 1});
        csum = csum ^ w[15:8] ^ w[7:0];
      end
      sent = force_csum ? forced : csum;
      send_byte(sent, $urandom_range(0, max_gap), dc);
    end
    exp_done = !cnt_bad && (sent == csum);
    idle_cycle();
    wait_idle(name, 40);
    repeat (3) idle_cycle();

    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_nwrites: got %0d required %0d", name, mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i].addr !== exp_q[i].addr || mon_q[i].data !== exp_q[i].data ||
          mon_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL %s_write%0d: got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                 name, i, mon_q[i].addr, mon_q[i].data, mon_q[i].cyc, exp_q[i].addr,
                 exp_q[i].data, exp_q[i].cyc);
      end
    end

    checks++;
    if ({bus.load_busy, bus.load_done, bus.load_err} !== {1'b0, exp_done, !exp_done}) begin
      errors++;
      $display("FAIL %s_end_flags: busy/done/err got %b%b%b required 0%b%b", name, bus.load_busy,
               bus.load_done, bus.load_err, exp_done, !exp_done);
    end

    if (exp_q.size() > 0) begin
      checks++;
      if (bus.ImemData !== exp_q[$].data || bus.addr_to_write !== exp_q[$].addr) begin
        errors++;
        $display("FAIL %s_hold: got addr=%h data=%h required addr=%h data=%h", name,
                 bus.addr_to_write, bus.ImemData, exp_q[$].addr, exp_q[$].data);
      end
    end

    checks++;
    if (pw_viol != pw0) begin
      errors++;
      $display("FAIL %s_pulse_width: multi-cycle pulses got %0d required 0", name, pw_viol - pw0);
    end
  endtask

  task automatic fill_random(input int n);
    tx_words.delete();
    for (int i = 0; i < n; i++) tx_words.push_back(16'($urandom));
  endtask

  task automatic test_reset();
    int dc;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ImemWrite, bus.ImemData, bus.addr_to_write, bus.load_busy, bus.load_done,
         bus.load_err} !== '0) begin
      errors++;
      $display("FAIL reset_values: got w=%b d=%h a=%h b/d/e=%b%b%b required all 0", bus.ImemWrite,
               bus.ImemData, bus.addr_to_write, bus.load_busy, bus.load_done, bus.load_err);
    end
    rst_n = 1'b1;
    mon_q.delete();
    // Without a start, any traffic must be ignored.
    send_byte(8'h00, 0, dc);
    send_byte(8'h01, 0, dc);
    send_byte(8'h12, 0, dc);
    send_byte(8'h34, 0, dc);
    repeat (3) idle_cycle();
    checks++;
    if (mon_q.size() != 0 || bus.load_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: got writes=%0d busy=%b required writes=0 busy=0", mon_q.size(),
               bus.load_busy);
    end
  endtask

  task automatic test_basic_load();
    tx_words = '{16'h1234, 16'hABCD, 16'h00FF};
    load_and_check("basic", 16'd3, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    tx_words = '{16'h1234, 16'hABCD, 16'h00FF};
    load_and_check("bad_csum", 16'd3, 1'b1, 8'h00, 0, 1'b0);
  endtask

  task automatic test_bad_count();
    load_and_check("count_zero", 16'h0000, 1'b0, 8'h00, 0, 1'b0);
    load_and_check("count_big", 16'h0201, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 6; k++) begin
      int n;
      bit bad;
      n   = $urandom_range(1, 20);
      bad = ($urandom_range(0, 3) == 0);
      fill_random(n);
      load_and_check($sformatf("rand%0d", k), 16'(n), bad, 8'($urandom), 3, k[0]);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(DEPTH);
    load_and_check("full_b2b", 16'(DEPTH), 1'b0, 8'h00, 0, 1'b1);
  endtask

  task automatic test_timeout();
    int dc;
    int lo_cyc;
    mon_q.delete();
    pulse_start(1'b0);
    send_byte(8'h00, 0, dc);
    send_byte(8'h02, 0, dc);
    send_byte(8'h5A, 0, dc);
    repeat (4) idle_cycle();
    pulse_start(1'b0);
    // Start above was mid-frame; this byte must still complete word 0.
    send_byte(8'h3C, 0, lo_cyc);
    repeat (8) idle_cycle();
    checks++;
    if ({bus.load_busy, bus.load_err} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_still_busy: busy/err got %b%b required 10", bus.load_busy, bus.load_err);
    end
    repeat (20) idle_cycle();
    checks++;
    if ({bus.load_busy, bus.load_done, bus.load_err} !== 3'b001) begin
      errors++;
      $display("FAIL tmo_flags: busy/done/err got %b%b%b required 001", bus.load_busy,
               bus.load_done, bus.load_err);
    end
    checks++;
    if (mon_q.size() != 1) begin
      errors++;
      $display("FAIL tmo_nwrites: got %0d required 1", mon_q.size());
    end else begin
      checks++;
      if (mon_q[0].addr !== '0 || mon_q[0].data !== 16'h5A3C || mon_q[0].cyc != lo_cyc + 1) begin
        errors++;
        $display("FAIL tmo_write: got addr=%h data=%h cyc=%0d required addr=0 data=5a3c cyc=%0d",
                 mon_q[0].addr, mon_q[0].data, mon_q[0].cyc, lo_cyc + 1);
      end
    end
    fill_random(2);
    load_and_check("restart_after_err", 16'd2, 1'b0, 8'h00, 1, 1'b0);
  endtask

  task automatic test_reset_midload();
    int dc;
    fill_random(4);
    pulse_start(1'b0);
    send_byte(8'h00, 0, dc);
    send_byte(8'h04, 0, dc);
    send_byte(tx_words[0][15:8], 0, dc);
    send_byte(tx_words[0][7:0], 0, dc);
    idle_cycle();
    checks++;
    if (bus.ImemWrite !== 1'b1) begin
      errors++;
      $display("FAIL midload_first_write: ImemWrite got %b required 1", bus.ImemWrite);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ImemWrite, bus.ImemData, bus.addr_to_write, bus.load_busy, bus.load_done,
         bus.load_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got w=%b d=%h a=%h b/d/e=%b%b%b required all 0", bus.ImemWrite,
               bus.ImemData, bus.addr_to_write, bus.load_busy, bus.load_done, bus.load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_q.delete();
    for (int i = 1; i < 4; i++) begin
      send_byte(tx_words[i][15:8], 0, dc);
      send_byte(tx_words[i][7:0], 0, dc);
    end
    repeat (4) idle_cycle();
    checks++;
    if (mon_q.size() != 0 || {bus.load_busy, bus.load_done, bus.load_err} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_quiet: got writes=%0d b/d/e=%b%b%b required writes=0 b/d/e=000",
               mon_q.size(), bus.load_busy, bus.load_done, bus.load_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_bad_count();
    test_random_loads();
    test_back_to_back();
    test_timeout();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
